udl_cmd_sequencer: RTL and testbench

- Command-issuing front end for the 4-register up/down/load counter bank (UDL_Count).
- Accepts queued commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the bank's control inputs (rst, up, down, load, in, rs, rd) cycle by cycle, repeating each command a programmable number of times.
- Sits between a host/microcode source and the counter bank; it is the initiator for the bank's control interface.

---
 rtl/udl_pkg.sv | 14 +
 rtl/udl_cmd_fifo.sv | 43 ++++
 rtl/udl_cmd_sequencer.sv | 95 +++++++++
 tb/tb_udl_cmd_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/udl_pkg.sv
// udl_pkg: shared opcodes, FSM states and command field widths for the UDL command sequencer
package udl_pkg;
  localparam int OP_W = 3;
  localparam int SEL_W = 2;
  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_CLR = 3'b001;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b010;
  localparam logic [OP_W-1:0] OP_INC = 3'b011;
  localparam logic [OP_W-1:0] OP_DEC = 3'b100;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;
  function automatic int cmd_w(input int n, input int rw);
    return OP_W + 2 * SEL_W + n + rw;
  endfunction
endpackage

// File: rtl/udl_cmd_fifo.sv
// udl_cmd_fifo: synchronous command FIFO with flush and async active-low reset
// ports: clk, rst_n, flush (drops all entries), push/din (write), pop/dout (head), full, empty
module udl_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign wr = push && !full && !flush;
  assign rd = pop && !empty && !flush;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/udl_cmd_sequencer.sv
// udl_cmd_sequencer: queues commands and drives the UDL counter bank controls, repeating each rep+1 cycles
// ports: clk, rst_n (async, active-low), flush; cmd_valid/cmd_ready handshake with cmd_op/rs/rd/imm/rep;
//        bank_rst/up/down/load/in/rs/rd to the bank (registered); busy, done (final issue cycle)
module udl_cmd_sequencer
  import udl_pkg::*;
#(
  parameter int N = 4,
  parameter int DEPTH = 4,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [1:0]    cmd_rs,
  input  logic [1:0]    cmd_rd,
  input  logic [N-1:0]  cmd_imm,
  input  logic [RW-1:0] cmd_rep,
  output logic          bank_rst,
  output logic          bank_up,
  output logic          bank_down,
  output logic          bank_load,
  output logic [N-1:0]  bank_in,
  output logic [1:0]    bank_rs,
  output logic [1:0]    bank_rd,
  output logic          busy,
  output logic          done
);
  localparam int CW = cmd_w(N, RW);
  state_t state, state_nx;
  logic [RW-1:0] cnt, cnt_nx;
  logic [CW-1:0] head;
  logic [OP_W-1:0] h_op;
  logic [SEL_W-1:0] h_rs, h_rd;
  logic [N-1:0] h_imm, in_nx;
  logic [RW-1:0] h_rep;
  logic [1:0] rs_nx, rd_nx;
  logic full, empty, last, load, idle;
  logic rst_nx, up_nx, down_nx, load_nx;
  assign {h_op, h_rs, h_rd, h_imm, h_rep} = head;
  udl_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(cmd_valid && !full),
    .pop(load),
    .din({cmd_op, cmd_rs, cmd_rd, cmd_imm, cmd_rep}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // the head is popped into the output registers as it starts issuing, so a
  // finishing command hands over to the next one on the same edge
  assign cmd_ready = !full;
  assign last = state == ST_ISSUE && cnt == '0;
  assign load = !flush && !empty && (state == ST_IDLE || last);
  assign idle = flush || (last && !load);
  assign done = last && !flush;
  assign busy = state == ST_ISSUE || !empty;
  always_comb begin
    state_nx = idle ? ST_IDLE : load ? ST_ISSUE : state;
    cnt_nx = load ? h_rep : state == ST_ISSUE ? cnt - RW'(1) : cnt;
    rst_nx = load ? h_op == OP_CLR : !idle && bank_rst;
    up_nx = load ? h_op == OP_INC : !idle && bank_up;
    down_nx = load ? h_op == OP_DEC : !idle && bank_down;
    load_nx = load ? h_op == OP_LOAD : !idle && bank_load;
    in_nx = load ? (h_op == OP_LOAD ? h_imm : '0) : idle ? '0 : bank_in;
    rs_nx = load ? h_rs : idle ? '0 : bank_rs;
    rd_nx = load ? h_rd : idle ? '0 : bank_rd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      bank_rst <= 1'b0;
      bank_up <= 1'b0;
      bank_down <= 1'b0;
      bank_load <= 1'b0;
      bank_in <= '0;
      bank_rs <= '0;
      bank_rd <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bank_rst <= rst_nx;
      bank_up <= up_nx;
      bank_down <= down_nx;
      bank_load <= load_nx;
      bank_in <= in_nx;
      bank_rs <= rs_nx;
      bank_rd <= rd_nx;
    end
endmodule

// File: tb/tb_udl_cmd_sequencer.sv
// tb_udl_cmd_sequencer: directed self-checking bench with a behavioural model of the counter bank
module tb_udl_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n, flush, cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rs, cmd_rd;
  logic [3:0] cmd_imm, cmd_rep;
  logic bank_rst, bank_up, bank_down, bank_load, busy, done;
  logic [3:0] bank_in;
  logic [1:0] bank_rs, bank_rd;
  logic [3:0] r [4];
  int n_vec = 0;
  int n_err = 0;

  udl_cmd_sequencer #(.N(4), .DEPTH(4), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_rep(cmd_rep),
    .bank_rst(bank_rst), .bank_up(bank_up), .bank_down(bank_down), .bank_load(bank_load),
    .bank_in(bank_in), .bank_rs(bank_rs), .bank_rd(bank_rd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst_n) for (int i = 0; i < 4; i++) r[i] <= 4'h0;
    else if (bank_rst) r[bank_rd] <= 4'h0;
    else if (bank_load) r[bank_rd] <= bank_in;
    else if (bank_up) r[bank_rd] <= r[bank_rs] + 4'h1;
    else if (bank_down) r[bank_rd] <= r[bank_rs] - 4'h1;
    else r[bank_rd] <= r[bank_rs];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rd,
                       input logic [3:0] imm, input logic [3:0] rep);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rs = rs;
    cmd_rd = rd;
    cmd_imm = imm;
    cmd_rep = rep;
  endtask

  function automatic logic [3:0] ctl();
    return {bank_rst, bank_up, bank_down, bank_load};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(3'd0, 2'd0, 2'd0, 4'h0, 4'h0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {4'h0, ctl()}, 8'h00);
    chk("rst_in_rs_rd", {bank_in, bank_rs, bank_rd}, 8'h00);
    chk("rst_busy_done", {busy, done}, 8'h00);
    chk("rst_ready", cmd_ready, 8'h01);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_busy", {cmd_ready, busy}, 8'h02);
    // 1: single LOAD
    drive(3'd2, 2'd0, 2'd1, 4'hA, 4'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_queued_busy", busy, 8'h01);
    chk("t1_not_yet", bank_load, 8'h00);
    @(negedge clk);
    chk("t1_load", {bank_load, bank_in, bank_rd, done}, {1'b1, 4'hA, 2'd1, 1'b1});
    @(negedge clk);
    chk("t1_after", {bank_load, done, busy}, 8'h00);
    chk("t1_r1", r[1], 8'h0A);
    // 2: INC rep=3
    drive(3'd3, 2'd1, 2'd1, 4'h0, 4'h3);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_up", bank_up, 8'h01);
      chk("t2_done", done, (i == 3) ? 8'h01 : 8'h00);
    end
    @(negedge clk);
    chk("t2_end", {bank_up, busy}, 8'h00);
    chk("t2_r1", r[1], 8'h0E);
    // 3: fill FIFO behind a 16-cycle DEC
    drive(3'd4, 2'd3, 2'd3, 4'h0, 4'hF);
    @(negedge clk);
    drive(3'd2, 2'd0, 2'd0, 4'h5, 4'h0);
    @(negedge clk);
    chk("t3_dec_start", {bank_down, bank_rd, done}, {1'b1, 2'd3, 1'b0});
    chk("t3_ready1", cmd_ready, 8'h01);
    drive(3'd3, 2'd0, 2'd0, 4'h0, 4'h0);
    @(negedge clk);
    drive(3'd7, 2'd0, 2'd0, 4'h0, 4'h0);
    @(negedge clk);
    drive(3'd4, 2'd0, 2'd0, 4'h0, 4'h0);
    @(negedge clk);
    chk("t3_full", cmd_ready, 8'h00);
    drive(3'd3, 2'd2, 2'd2, 4'h0, 4'h0);
    @(negedge clk);
    chk("t3_held1", cmd_ready, 8'h00);
    @(negedge clk);
    chk("t3_held2", cmd_ready, 8'h00);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_dec_last", {bank_down, done}, 8'h03);
    @(negedge clk);
    chk("t3_c1", {bank_load, bank_in, done}, {1'b1, 4'h5, 1'b1});
    chk("t3_r3_16dec", r[3], 8'h00);
    @(negedge clk);
    chk("t3_c2", {ctl(), done}, 8'b0100_1);
    @(negedge clk);
    chk("t3_c3_nop", {ctl(), done, busy}, 8'b00_0000_11);
    @(negedge clk);
    chk("t3_c4", {ctl(), done}, 8'b0010_1);
    @(negedge clk);
    chk("t3_idle", {ctl(), done, busy}, 8'h00);
    chk("t3_r0", r[0], 8'h05);
    // 4: CLR then DEC (wrap)
    drive(3'd1, 2'd2, 2'd2, 4'h0, 4'h0);
    @(negedge clk);
    drive(3'd4, 2'd2, 2'd2, 4'h0, 4'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_clr", {ctl(), bank_rd, done}, 8'b0_1000_10_1);
    @(negedge clk);
    chk("t4_dec", {ctl(), done}, 8'b0010_1);
    chk("t4_r2_clr", r[2], 8'h00);
    @(negedge clk);
    chk("t4_r2_wrap", r[2], 8'h0F);
    chk("t4_idle", busy, 8'h00);
    // 5: flush mid-command with two queued, plus a discarded push
    drive(3'd3, 2'd1, 2'd1, 4'h0, 4'h5);
    @(negedge clk);
    drive(3'd2, 2'd0, 2'd1, 4'h3, 4'h0);
    @(negedge clk);
    chk("t5_issue1", {bank_up, done}, 8'h02);
    drive(3'd3, 2'd1, 2'd1, 4'h0, 4'h0);
    @(negedge clk);
    chk("t5_issue2", {bank_up, done}, 8'h02);
    drive(3'd1, 2'd0, 2'd0, 4'h0, 4'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_flush_out", {ctl(), bank_in}, 8'h00);
    chk("t5_flush_sel", {bank_rs, bank_rd}, 8'h00);
    chk("t5_flush_flags", {busy, done, cmd_ready}, 8'h01);
    chk("t5_r1", r[1], 8'h00);
    @(negedge clk);
    chk("t5_stay_idle", {ctl(), busy, done}, 8'h00);
    // 6: async reset mid-issue
    drive(3'd3, 2'd1, 2'd1, 4'h0, 4'h7);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t6_issuing", {bank_up, busy}, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctl", {ctl(), bank_in}, 8'h00);
    chk("t6_async_sel", {bank_rs, bank_rd, busy, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after", {busy, done, cmd_ready, bank_up}, 8'h02);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
